// File: rtl/clock_activity_monitor.sv
// clock_activity_monitor
//   Watches CHANNELS foreign clocks. Each foreign clock arrives as a toggle bit
//   that flips once every N of its own cycles. For every channel the block
//   counts edges over a gate window of GATE_CYCLES Clock cycles, then reports
//   the count, whether the channel is present and whether the count saturated.
//   It also blinks one activity LED per channel. All logic runs on Clock.
//
// Ports
//   Clock       internal reference clock (sole clock)
//   ResetN      asynchronous active-low reset
//   ToggleIn    [CHANNELS] asynchronous toggle bits, one per foreign clock
//   Enable      measurement enable; 0 holds the window and running counts at 0
//   EdgeCount   [CHANNELS*COUNT_WIDTH] last completed window count, channel i
//               in bits [i*COUNT_WIDTH +: COUNT_WIDTH]
//   CountValid  one-cycle pulse when EdgeCount/Present/Overflow update
//   Present     [CHANNELS] last window count >= MIN_EDGES
//   Overflow    [CHANNELS] last window count saturated
//   LED         [CHANNELS] MSB of each channel's 32-bit blink phase accumulator

// Per-channel lane: synchroniser, edge detector, running count, blink accumulator.
//   Terminal is the shared end-of-window strobe from the top level.
module clock_activity_monitor_lane #(
  parameter int          COUNT_WIDTH     = 24,
  parameter int          MIN_EDGES       = 16,
  parameter logic [31:0] BLINK_INCREMENT = 32'h111
) (
  input  logic                   Clock,
  input  logic                   ResetN,
  input  logic                   ToggleIn,
  input  logic                   Enable,
  input  logic                   Terminal,
  output logic [COUNT_WIDTH-1:0] EdgeCount,
  output logic                   Present,
  output logic                   Overflow,
  output logic                   LED
);
  localparam logic [COUNT_WIDTH-1:0] CountMax = '1;
  localparam logic [COUNT_WIDTH-1:0] MinEdges = COUNT_WIDTH'(MIN_EDGES);

  logic                   s1, s2, s3;
  logic                   edgeSeen;
  logic                   satNow;
  logic [COUNT_WIDTH-1:0] runCount;
  logic [COUNT_WIDTH-1:0] nextCount;
  logic                   runOvf;
  logic [31:0]            phaseAcc;

  // s1/s2 resolve metastability; s3 is history so both toggle directions
  // register as an edge.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= ToggleIn;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edgeSeen = s2 ^ s3;
  // Saturation means an edge arrived that the count could not absorb.
  assign satNow   = edgeSeen && (runCount == CountMax);

  always_comb begin
    nextCount = runCount;
    if (edgeSeen && !satNow) nextCount = runCount + 1'b1;
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      runCount  <= '0;
      runOvf    <= 1'b0;
      EdgeCount <= '0;
      Present   <= 1'b0;
      Overflow  <= 1'b0;
    end else if (!Enable) begin
      runCount <= '0;
      runOvf   <= 1'b0;
    end else if (Terminal) begin
      // The terminal-cycle edge is folded into the closing window.
      EdgeCount <= nextCount;
      Overflow  <= runOvf | satNow;
      Present   <= (nextCount >= MinEdges);
      runCount  <= '0;
      runOvf    <= 1'b0;
    end else begin
      runCount <= nextCount;
      runOvf   <= runOvf | satNow;
    end
  end

  // Blink accumulator runs regardless of Enable so the LED shows raw activity.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN)       phaseAcc <= '0;
    else if (edgeSeen) phaseAcc <= phaseAcc + BLINK_INCREMENT;
  end

  assign LED = phaseAcc[31];
endmodule

module clock_activity_monitor #(
  parameter int          CHANNELS        = 2,
  parameter int          GATE_CYCLES     = 1000000,
  parameter int          COUNT_WIDTH     = 24,
  parameter int          MIN_EDGES       = 16,
  parameter logic [31:0] BLINK_INCREMENT = 32'h111
) (
  input  logic                            Clock,
  input  logic                            ResetN,
  input  logic [CHANNELS-1:0]             ToggleIn,
  input  logic                            Enable,
  output logic [CHANNELS*COUNT_WIDTH-1:0] EdgeCount,
  output logic                            CountValid,
  output logic [CHANNELS-1:0]             Present,
  output logic [CHANNELS-1:0]             Overflow,
  output logic [CHANNELS-1:0]             LED
);
  localparam int             WinW    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [WinW-1:0] WinLast = WinW'(GATE_CYCLES - 1);

  logic [WinW-1:0] winCnt;
  logic            terminal;

  assign terminal = Enable && (winCnt == WinLast);

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      winCnt     <= '0;
      CountValid <= 1'b0;
    end else begin
      CountValid <= terminal;
      if (!Enable || terminal) winCnt <= '0;
      else                     winCnt <= winCnt + 1'b1;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : gLane
    clock_activity_monitor_lane #(
      .COUNT_WIDTH    (COUNT_WIDTH),
      .MIN_EDGES      (MIN_EDGES),
      .BLINK_INCREMENT(BLINK_INCREMENT)
    ) uLane (
      .Clock    (Clock),
      .ResetN   (ResetN),
      .ToggleIn (ToggleIn[g]),
      .Enable   (Enable),
      .Terminal (terminal),
      .EdgeCount(EdgeCount[g*COUNT_WIDTH +: COUNT_WIDTH]),
      .Present  (Present[g]),
      .Overflow (Overflow[g]),
      .LED      (LED[g])
    );
  end
endmodule

// File: tb/tb_clock_activity_monitor.sv
module tb_clock_activity_monitor;
  localparam int          CH   = 2;
  localparam int          G    = 100;
  localparam int          CW   = 5;
  localparam int          MINE = 16;
  localparam logic [31:0] INC  = 32'h8000_0000;
  localparam int          MAXC = (1 << CW) - 1;

  logic                 Clock;
  logic                 ResetN;
  logic [CH-1:0]        ToggleIn;
  logic                 Enable;
  logic [CH*CW-1:0]     EdgeCount;
  logic                 CountValid;
  logic [CH-1:0]        Present;
  logic [CH-1:0]        Overflow;
  logic [CH-1:0]        LED;

  clock_activity_monitor #(
    .CHANNELS(CH), .GATE_CYCLES(G), .COUNT_WIDTH(CW),
    .MIN_EDGES(MINE), .BLINK_INCREMENT(INC)
  ) dut (
    .Clock(Clock), .ResetN(ResetN), .ToggleIn(ToggleIn), .Enable(Enable),
    .EdgeCount(EdgeCount), .CountValid(CountValid), .Present(Present),
    .Overflow(Overflow), .LED(LED)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Delayed input samples give the two-register synchroniser latency; the
  // window itself is kept as an unsaturated edge total clamped at publish.
  logic [CH-1:0]    tq1, tq2, tq3;
  int               idx;
  int               total [CH];
  int unsigned      ledEdges [CH];
  logic [CH*CW-1:0] mCount;
  logic [CH-1:0]    mPres, mOvf;
  logic             mValid;

  always @(posedge Clock or negedge ResetN) begin : model
    logic [CH-1:0] e;
    int t, cl;
    if (!ResetN) begin
      tq1 <= '0; tq2 <= '0; tq3 <= '0;
      idx <= 0;
      for (int c = 0; c < CH; c++) begin
        total[c]    <= 0;
        ledEdges[c] <= 0;
      end
      mCount <= '0; mPres <= '0; mOvf <= '0; mValid <= 1'b0;
    end else begin
      e = tq2 ^ tq3;
      tq1 <= ToggleIn; tq2 <= tq1; tq3 <= tq2;
      mValid <= 1'b0;
      for (int c = 0; c < CH; c++)
        if (e[c]) ledEdges[c] <= ledEdges[c] + 1;
      if (Enable) begin
        if (idx == G - 1) begin
          idx    <= 0;
          mValid <= 1'b1;
          for (int c = 0; c < CH; c++) begin
            t  = total[c] + int'(e[c]);
            cl = (t > MAXC) ? MAXC : t;
            mCount[c*CW +: CW] <= CW'(cl);
            mOvf[c]  <= (t > MAXC);
            mPres[c] <= (cl >= MINE);
            total[c] <= 0;
          end
        end else begin
          idx <= idx + 1;
          for (int c = 0; c < CH; c++) total[c] <= total[c] + int'(e[c]);
        end
      end else begin
        idx <= 0;
        for (int c = 0; c < CH; c++) total[c] <= 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge Clock) begin : compare
    logic [CH-1:0] expLed;
    logic [31:0]   prod;
    for (int c = 0; c < CH; c++) begin
      prod      = ledEdges[c] * INC;
      expLed[c] = prod[31];
    end
    chk("CountValid", 64'(CountValid), 64'(mValid));
    chk("EdgeCount",  64'(EdgeCount),  64'(mCount));
    chk("Present",    64'(Present),    64'(mPres));
    chk("Overflow",   64'(Overflow),   64'(mOvf));
    chk("LED",        64'(LED),        64'(expLed));
  end

  // ---------------- stimulus ----------------
  int mode [CH];   // 0 static, 1 fixed period, 2 random period
  int per  [CH];
  int cd   [CH];

  task automatic tick();
    @(posedge Clock);
    #1;
    for (int c = 0; c < CH; c++) begin
      if (mode[c] != 0) begin
        if (cd[c] == 0) begin
          ToggleIn[c] = ~ToggleIn[c];
          cd[c] = (mode[c] == 1) ? per[c] - 1 : int'($urandom_range(1, 8));
        end else begin
          cd[c]--;
        end
      end
    end
  endtask

  task automatic setMode(input int c, input int m, input int p);
    mode[c] = m;
    per[c]  = p;
    cd[c]   = 0;
  endtask

  task automatic waitValid(output int n);
    n = 0;
    for (int i = 1; i <= 3 * G; i++) begin
      tick();
      @(negedge Clock);
      if (CountValid === 1'b1) begin
        n = i;
        break;
      end
    end
    if (n == 0) chk("valid_timeout", 64'(0), 64'(1));
  endtask

  task automatic assertReset();
    ResetN = 1'b0;
    #1;
    chk("rst_EdgeCount",  64'(EdgeCount),  64'(0));
    chk("rst_CountValid", 64'(CountValid), 64'(0));
    chk("rst_Present",    64'(Present),    64'(0));
    chk("rst_Overflow",   64'(Overflow),   64'(0));
    chk("rst_LED",        64'(LED),        64'(0));
  endtask

  initial begin
    int n;
    logic prev;
    logic saw;
    ResetN   = 1'b1;
    Enable   = 1'b0;
    ToggleIn = '0;
    for (int c = 0; c < CH; c++) setMode(c, 2, 0);
    #1 ResetN = 1'b0;
    repeat (3) tick();
    ResetN = 1'b1;
    Enable = 1'b1;

    // Random activity, then reset mid-window.
    repeat (150) tick();
    tick();
    assertReset();
    repeat (3) tick();
    for (int c = 0; c < CH; c++) setMode(c, 0, 0);
    ToggleIn = '0;
    tick();
    ResetN = 1'b1;
    repeat (G - 1) tick();
    @(negedge Clock);
    chk("post_rst_quiet_valid", 64'(CountValid), 64'(0));
    chk("post_rst_quiet_count", 64'(EdgeCount), 64'(0));
    waitValid(n);
    chk("first_window_len", 64'(n), 64'(1));

    // ch0 toggles every 4 cycles, ch1 static.
    setMode(0, 1, 4);
    waitValid(n);
    for (int k = 0; k < 2; k++) begin
      waitValid(n);
      chk("cnt_period",  64'(n), 64'(G));
      chk("cnt_ch0",     64'(EdgeCount[0 +: CW]), 64'(25));
      chk("cnt_ch1",     64'(EdgeCount[CW +: CW]), 64'(0));
      chk("cnt_present", 64'(Present), 64'(2'b01));
      chk("cnt_ovf",     64'(Overflow), 64'(2'b00));
    end

    // Saturation: 50 edges per window against a 5-bit count.
    setMode(0, 1, 2);
    waitValid(n);
    waitValid(n);
    chk("sat_ch0",     64'(EdgeCount[0 +: CW]), 64'(MAXC));
    chk("sat_ovf",     64'(Overflow), 64'(2'b01));
    chk("sat_present", 64'(Present), 64'(2'b01));
    setMode(0, 0, 0);
    waitValid(n);
    waitValid(n);
    chk("quiet_ch0",     64'(EdgeCount[0 +: CW]), 64'(0));
    chk("quiet_ovf",     64'(Overflow), 64'(0));
    chk("quiet_present", 64'(Present), 64'(0));

    // Enable dropped mid-window for 30 cycles.
    setMode(0, 1, 3);
    setMode(1, 1, 5);
    waitValid(n);
    repeat (50) tick();
    Enable = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      @(negedge Clock);
      saw |= CountValid;
    end
    chk("dis_no_valid", 64'(saw), 64'(0));
    Enable = 1'b1;
    waitValid(n);
    chk("reen_window_len", 64'(n), 64'(G));

    // LED latency while disabled.
    Enable = 1'b0;
    setMode(0, 0, 0);
    setMode(1, 0, 0);
    repeat (10) tick();
    for (int k = 0; k < 3; k++) begin
      prev = LED[0];
      tick();
      ToggleIn[0] = ~ToggleIn[0];
      n = 0;
      for (int i = 1; i <= 10; i++) begin
        tick();
        if (LED[0] !== prev) begin
          n = i;
          break;
        end
      end
      chk("led_latency", 64'(n), 64'(3));
      repeat (4) tick();
    end

    // Edge detected exactly in the terminal cycle.
    Enable = 1'b1;
    waitValid(n);
    waitValid(n);
    repeat (G - 3) tick();
    ToggleIn[0] = ~ToggleIn[0];
    waitValid(n);
    chk("term_len", 64'(n), 64'(3));
    chk("term_ch0", 64'(EdgeCount[0 +: CW]), 64'(1));
    waitValid(n);
    chk("term_next_ch0", 64'(EdgeCount[0 +: CW]), 64'(0));

    // Random traffic with random enable drops and one reset.
    setMode(0, 2, 0);
    setMode(1, 2, 0);
    for (int i = 0; i < 3000; i++) begin
      tick();
      if ($urandom_range(0, 59) == 0) Enable = ~Enable;
      if (i == 1500) begin
        assertReset();
        repeat (3) tick();
        ResetN = 1'b1;
      end
    end
    repeat (2) @(negedge Clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
